rollo_ct_mask: RTL and testbench

- Downstream consumer of the SHA3-512 wrapper in the ROLLO-II encrypt datapath.
- On a new digest, it forms the masked message ct = msg XOR G(E) word by word:
  - reads message words from a synchronous single-port message RAM;
  - XORs each word with the matching digest slice;
  - writes the result to the ciphertext RAM.
- Signals completion and zeroizes the captured digest afterwards.

---
 rtl/rollo_ct_mask_pkg.sv | 23 ++
 rtl/rollo_edge_detect.sv | 20 ++
 rtl/rollo_ct_mask.sv | 146 ++++++++++++++
 tb/tb_rollo_ct_mask.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rollo_ct_mask_pkg.sv
// Shared constants and state encoding for the ROLLO-II ct = msg ^ G(E) masking stage.
package rollo_ct_mask_pkg;

    localparam int unsigned ROLLO_DIGEST_BITS = 512;
    localparam int unsigned ROLLO_WORD_W      = 64;

    // Masking sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Ceiling log2 with a floor of 1 so single-word builds still get an address bit
    function automatic int unsigned rollo_clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rollo_edge_detect.sv
// Rising-edge pulse generator for level-style ready signals.
// Ports: clk, rst (async active-high), i_level (level input),
//        o_rise_c (combinational one-cycle pulse on 0->1 transition).
module rollo_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise_c
);

    logic r_level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_level_q <= 1'b0;
        else     r_level_q <= i_level;
    end

    assign o_rise_c = i_level & ~r_level_q;

endmodule

// File: rtl/rollo_ct_mask.sv
// Masks the message with the captured SHA3-512 digest word by word: reads the
// message RAM, XORs with the matching digest slice (word 0 = digest MSBs) and
// writes the ciphertext RAM, then pulses done and zeroizes the digest copy.
// Ports: clk, rst (async active-high); digest_valid/digest from the hash;
//        msg_rd/msg_addr/msg_rdata to the message RAM (1-cycle read latency);
//        ct_we/ct_addr/ct_wdata to the ciphertext RAM;
//        busy, done (pulse), overrun (sticky retrigger-while-busy flag).
module rollo_ct_mask
    import rollo_ct_mask_pkg::*;
#(
    parameter  int unsigned W           = ROLLO_WORD_W,
    parameter  int unsigned DIGEST_BITS = ROLLO_DIGEST_BITS,
    localparam int unsigned NW          = DIGEST_BITS / W,
    localparam int unsigned AW          = rollo_clog2(NW)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   digest_valid,
    input  logic [DIGEST_BITS-1:0] digest,
    output logic                   msg_rd,
    output logic [AW-1:0]          msg_addr,
    input  logic [W-1:0]           msg_rdata,
    output logic                   ct_we,
    output logic [AW-1:0]          ct_addr,
    output logic [W-1:0]           ct_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NW - 1);

    if ((DIGEST_BITS % W) != 0 || NW == 0) begin : g_bad_width
        $error("rollo_ct_mask: DIGEST_BITS must be a nonzero multiple of W");
    end

    state_e                 r_state, w_state_nxt;
    logic [DIGEST_BITS-1:0] r_dig, w_dig_nxt;
    logic [AW-1:0]          r_rd_cnt, w_rd_cnt_nxt;
    logic                   r_msg_rd, w_msg_rd_nxt;
    logic [AW-1:0]          r_msg_addr, w_msg_addr_nxt;
    logic                   r_ct_we;
    logic [AW-1:0]          r_ct_addr;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_overrun, w_overrun_nxt;
    logic                   w_start;

    rollo_edge_detect u_dv_edge (
        .clk      (clk),
        .rst      (rst),
        .i_level  (digest_valid),
        .o_rise_c (w_start)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dig      <= '0;
            r_rd_cnt   <= '0;
            r_msg_rd   <= 1'b0;
            r_msg_addr <= '0;
            r_ct_we    <= 1'b0;
            r_ct_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dig      <= w_dig_nxt;
            r_rd_cnt   <= w_rd_cnt_nxt;
            r_msg_rd   <= w_msg_rd_nxt;
            r_msg_addr <= w_msg_addr_nxt;
            // Write side trails the read by the RAM latency so address meets data
            r_ct_we    <= r_msg_rd;
            if (r_msg_rd) r_ct_addr <= r_msg_addr;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_dig_nxt      = r_dig;
        w_rd_cnt_nxt   = r_rd_cnt;
        w_msg_rd_nxt   = 1'b0;
        w_msg_addr_nxt = r_msg_addr;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_overrun_nxt  = r_overrun | (w_start & (r_state != ST_IDLE));

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_dig_nxt      = digest;
                    w_rd_cnt_nxt   = '0;
                    w_msg_rd_nxt   = 1'b1;
                    w_msg_addr_nxt = '0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                // Counter stops at the last word; exact compare keeps non-pow2 NW safe
                if (r_rd_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_rd_cnt_nxt   = r_rd_cnt + AW'(1);
                    w_msg_rd_nxt   = 1'b1;
                    w_msg_addr_nxt = r_rd_cnt + AW'(1);
                end
            end
            ST_DRAIN: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_dig_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Digest viewed as words; word 0 sits in the top bits
    logic [NW-1:0][W-1:0] w_dig_words;
    logic [W-1:0]         w_dig_word;

    assign w_dig_words = r_dig;
    assign w_dig_word  = w_dig_words[LAST_ADDR - r_ct_addr];

    assign msg_rd   = r_msg_rd;
    assign msg_addr = r_msg_addr;
    assign ct_we    = r_ct_we;
    assign ct_addr  = r_ct_addr;
    // RAM read data arrives unregistered, so the XOR sits directly on it
    assign ct_wdata = r_ct_we ? (msg_rdata ^ w_dig_word) : '0;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_rollo_ct_mask.sv
// Scoreboard bench for rollo_ct_mask with RAM models and a word-level reference.
module tb_rollo_ct_mask;

    localparam int unsigned TB_W  = 64;
    localparam int unsigned TB_DB = 512;
    localparam int unsigned NW    = TB_DB / TB_W;
    localparam int unsigned AW    = (NW > 1) ? $clog2(NW) : 1;

    logic              clk;
    logic              rst;
    logic              digest_valid;
    logic [TB_DB-1:0]  digest;
    logic              msg_rd;
    logic [AW-1:0]     msg_addr;
    logic [TB_W-1:0]   msg_rdata;
    logic              ct_we;
    logic [AW-1:0]     ct_addr;
    logic [TB_W-1:0]   ct_wdata;
    logic              busy;
    logic              done;
    logic              overrun;

    rollo_ct_mask #(.W(TB_W), .DIGEST_BITS(TB_DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .digest_valid (digest_valid),
        .digest       (digest),
        .msg_rd       (msg_rd),
        .msg_addr     (msg_addr),
        .msg_rdata    (msg_rdata),
        .ct_we        (ct_we),
        .ct_addr      (ct_addr),
        .ct_wdata     (ct_wdata),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    typedef struct packed {
        logic [31:0]     cyc;
        logic [AW-1:0]   addr;
        logic [TB_W-1:0] data;
    } wr_t;

    int unsigned     n_checks = 0;
    int unsigned     n_errs   = 0;
    int unsigned     cyc      = 0;
    wr_t             exp_q[$];
    int unsigned     done_q[$];
    logic [TB_W-1:0] msg_ram [NW];
    logic [TB_W-1:0] ct_ram  [NW];
    logic [TB_W-1:0] exp_ct  [NW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous message RAM: data one cycle after the read strobe
    always @(posedge clk) if (msg_rd) msg_rdata <= msg_ram[msg_addr];

    // Ciphertext RAM
    always @(posedge clk) if (ct_we) ct_ram[ct_addr] <= ct_wdata;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: word k is the k-th W-bit slice counted from the digest MSB
    function automatic logic [TB_W-1:0] dig_word(input logic [TB_DB-1:0] d, input int k);
        logic [TB_DB-1:0] s;
        s = d >> ((NW - 1 - k) * TB_W);
        return s[TB_W-1:0];
    endfunction

    function automatic logic [TB_DB-1:0] rand_digest();
        logic [TB_DB-1:0] d;
        d = '0;
        for (int j = 0; j < TB_DB / 32; j++) d = (d << 32) | TB_DB'($urandom);
        return d;
    endfunction

    function automatic logic [TB_W-1:0] rand_word();
        logic [TB_W-1:0] v;
        v = '0;
        for (int j = 0; j < (TB_W + 31) / 32; j++) v = (v << 32) | TB_W'($urandom);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise digest_valid now and push the expected writes and done cycle
    task automatic issue(input logic [TB_DB-1:0] d);
        wr_t e;
        int unsigned t;
        t = cyc;
        digest_valid = 1'b1;
        digest       = d;
        for (int k = 0; k < NW; k++) begin
            e.cyc  = 32'(t + 2 + k);
            e.addr = AW'(k);
            e.data = msg_ram[k] ^ dig_word(d, k);
            exp_q.push_back(e);
            exp_ct[k] = e.data;
        end
        done_q.push_back(t + NW + 2);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 300; i++) begin
            step();
            if (!busy && exp_q.size() == 0 && done_q.size() == 0) break;
        end
        if (i == 300) begin
            n_checks++;
            n_errs++;
            $display("FAIL run_timeout: busy=%0b pending_writes=%0d pending_done=%0d", busy, exp_q.size(), done_q.size());
        end
    endtask

    task automatic check_ct(input string tag);
        for (int k = 0; k < NW; k++) chk($sformatf("%s_ct[%0d]", tag, k), ct_ram[k], exp_ct[k]);
    endtask

    // Monitor: every write and done pulse must match the head of its queue
    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst) begin
            if (ct_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", ct_addr, '1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", ct_addr, e.addr);
                    chk("wr_data", ct_wdata, e.data);
                end
            end else begin
                chk("idle_wdata_zero", ct_wdata, 0);
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", done, 0);
                else begin
                    chk("done_cycle", cyc, done_q.pop_front());
                    chk("busy_during_done", busy, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TB_DB-1:0] d_inc;
        logic [TB_W-1:0]  saved [NW];
        int unsigned      t;

        rst          = 1'b1;
        digest_valid = 1'b0;
        digest       = '0;
        for (int k = 0; k < NW; k++) begin
            msg_ram[k] = '1 ^ TB_W'(k);
            ct_ram[k]  = TB_W'(32'hA5A5_5A5A) + TB_W'(k);
            exp_ct[k]  = ct_ram[k];
        end
        d_inc = '0;
        for (int i = 0; i < TB_DB / 8; i++) d_inc = (d_inc << 8) | TB_DB'(8'(i));

        step(); step();
        chk("rst_msg_rd", msg_rd, 0);
        chk("rst_ct_we", ct_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_msg_addr", msg_addr, 0);
        chk("rst_ct_addr", ct_addr, 0);
        chk("rst_wdata", ct_wdata, 0);
        rst = 1'b0;
        step();

        // Directed run with incrementing-byte digest
        issue(d_inc);
        step();
        digest_valid = 1'b0;
        chk("t1_busy_after_start", busy, 1);
        chk("t1_first_rd", msg_rd, 1);
        chk("t1_first_addr", msg_addr, 0);
        wait_done();
        chk("t1_busy_low", busy, 0);
        chk("t1_dig_zeroized", dut.r_dig == '0, 1);
        chk("t1_overrun", overrun, 0);
        check_ct("t1");

        // Level held high: one run only
        for (int k = 0; k < NW; k++) msg_ram[k] = rand_word();
        issue(rand_digest());
        repeat (50) step();
        digest_valid = 1'b0;
        wait_done();
        chk("t2_overrun", overrun, 0);
        check_ct("t2");

        // Back-to-back: second start at the earliest accepted cycle
        t = cyc;
        issue(rand_digest());
        step();
        digest_valid = 1'b0;
        while (cyc < t + NW + 3) step();
        issue(rand_digest());
        step();
        digest_valid = 1'b0;
        wait_done();
        chk("t3_overrun", overrun, 0);
        check_ct("t3");

        // Randomized runs
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < NW; k++) msg_ram[k] = rand_word();
            repeat ($urandom_range(0, 4)) step();
            issue(rand_digest());
            repeat ($urandom_range(1, 6)) step();
            digest_valid = 1'b0;
            wait_done();
            check_ct($sformatf("rnd%0d", r));
        end
        chk("rnd_overrun", overrun, 0);

        // Retrigger mid-run is ignored and flags overrun
        for (int k = 0; k < NW; k++) msg_ram[k] = rand_word();
        t = cyc;
        issue(rand_digest());
        step();
        digest_valid = 1'b0;
        while (cyc < t + 4) step();
        digest_valid = 1'b1;
        digest       = rand_digest();
        step();
        digest_valid = 1'b0;
        wait_done();
        chk("t4_overrun_set", overrun, 1);
        check_ct("t4");
        repeat (3) step();
        chk("t4_overrun_sticky", overrun, 1);

        // Asynchronous reset between edges mid-run aborts after address 2
        for (int k = 0; k < NW; k++) begin
            msg_ram[k] = rand_word();
            saved[k]   = exp_ct[k];
        end
        t = cyc;
        issue(rand_digest());
        step();
        digest_valid = 1'b0;
        while (cyc < t + 5) step();
        #1;
        rst = 1'b1;
        #1;
        chk("ar_msg_rd", msg_rd, 0);
        chk("ar_ct_we", ct_we, 0);
        chk("ar_busy", busy, 0);
        chk("ar_overrun", overrun, 0);
        chk("ar_msg_addr", msg_addr, 0);
        chk("ar_ct_addr", ct_addr, 0);
        chk("ar_wdata", ct_wdata, 0);
        chk("ar_dig_zero", dut.r_dig == '0, 1);
        chk("ar_writes_seen", 32'(NW - exp_q.size()), 3);
        exp_q.delete();
        done_q.delete();
        for (int k = 3; k < NW; k++) exp_ct[k] = saved[k];
        step();
        rst = 1'b0;
        step();
        check_ct("ar");
        chk("ar_no_done", done, 0);

        // Full run after reset
        for (int k = 0; k < NW; k++) msg_ram[k] = rand_word();
        issue(rand_digest());
        step();
        digest_valid = 1'b0;
        wait_done();
        check_ct("post_rst");
        chk("post_rst_overrun", overrun, 0);
        chk("post_rst_dig_zero", dut.r_dig == '0, 1);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
